triangle_sweep_ctrl: RTL and testbench
======================================

# triangle_sweep_ctrl

Sequencer for the DAQ triangle-wave output path. It latches a host-supplied sweep configuration from the USB3 command decoder, then walks a 16-bit code up and down between a low and a high bound at a programmable rate for a programmed number of periods. Each update is issued with a one-cycle strobe to the downstream waveform/DAC stage. Busy, done and error status go back to the host register file.

## Interface
Parameters:
- `W`, 16, code and config width
- `CW`, 16, period-counter width

Ports:
- `clk111`, in, 1, system clock; the only clock.
- `rst_n`, in, 1, asynchronous active-low reset.
- `start`, in, 1, one-cycle pulse; begins a sweep when idle.
- `stop`, in, 1, one-cycle pulse; aborts a running sweep.
- `cfg_lo`, in, W, lower bound (unsigned).
- `cfg_hi`, in, W, upper bound (unsigned).
- `cfg_step`, in, W, increment per update.
- `cfg_div`, in, 16, update interval minus 1, in clocks.
- `cfg_ncyc`, in, CW, number of full periods; 0 means run until `stop`.
- `cfg_dwell`, in, 16, peak dwell in update ticks; used only with `TRI_DWELL_EN`.
- `dac_code`, out, W, current code.
- `wave_stb`, out, 1, high for one cycle whenever `dac_code` is written.
- `busy`, out, 1, high while a sweep is active.
- `done`, out, 1, one-cycle pulse on return to IDLE.
- `cfg_err`, out, 1, one-cycle pulse when `start` is rejected.
- `cyc_cnt`, out, CW, number of completed periods in the current or last sweep.

## Operation
- States: IDLE, RISE, FALL; plus DWELL_HI and DWELL_LO when `TRI_DWELL_EN` is defined.
- **IDLE, start accepted:**
  - Check the configuration. If `cfg_lo >= cfg_hi` or `cfg_step == 0`, pulse `cfg_err` and stay in IDLE.
  - Otherwise latch all `cfg_*` into shadow registers; later `cfg_*` changes are ignored until the next start.
  - Clear `cyc_cnt`, set `dac_code = lo`, pulse `wave_stb`, and enter RISE.
- **Tick generation:** a tick occurs every `div+1` clocks. The prescaler restarts on each state entry from IDLE.
- **RISE, on each tick:**
  - Compute `sum = code + step` in W+1 bits.
  - If `sum >= hi`: set `code = hi` and enter FALL (or DWELL_HI).
  - Else: set `code = sum`.
  - Every write pulses `wave_stb`.
- **FALL, on each tick:**
  - Compute `diff = code - step` in W+1 bits, signed.
  - If `diff <= lo`: set `code = lo` and increment `cyc_cnt`, which saturates at all-ones.
    - If `ncyc != 0` and the new `cyc_cnt == ncyc`: go to IDLE and pulse `done`.
    - Else: go to RISE (or DWELL_LO).
  - Else: set `code = diff`.
- **Arithmetic rules:** no wrap-around is ever permitted; clamping to `hi`/`lo` is mandatory.
- **`stop` while busy:** next state is IDLE and `done` pulses. `dac_code` holds its last value and `wave_stb` is not asserted.
- **Ignored inputs:**
  - `start` while busy is ignored.
  - `stop` in IDLE is ignored.
  - `start` and `stop` in the same cycle in IDLE: stop wins and the start is ignored, with no `cfg_err`.
- **`busy`:** equals (state != IDLE).

## Timing
- **Reset values:** `dac_code = 0`, `wave_stb = 0`, `busy = 0`, `done = 0`, `cfg_err = 0`, `cyc_cnt = 0`; state is IDLE. All outputs are registered.
- **Start latency:** `start` sampled at edge N → `dac_code = lo`, `wave_stb = 1` and `busy = 1` visible after edge N; the first step follows `div+1` clocks later.
- **Stop latency:** `stop` sampled at edge N → `busy = 0` and `done = 1` after edge N.
- **Error latency:** `cfg_err` is asserted the cycle after the rejected `start`.
- **Finite-run completion:** `done` pulses in the same cycle that the final `lo` is written, together with `wave_stb`.
- **Strobe spacing:** successive `wave_stb` pulses are spaced `div+1` clocks apart. With `div = 0`, `wave_stb` can stay high on consecutive cycles.
- **Asynchronous reset mid-sweep:** immediately returns the block to the reset values; no `done` is produced.

## Configuration
Macro `TRI_DWELL_EN`:
- **Defined:** on reaching `hi` or `lo`, the block holds the code for `cfg_dwell` ticks in DWELL_HI/DWELL_LO with no `wave_stb`, then continues. With `cfg_dwell = 0` the dwell state is left on the first tick.
- **Not defined:**
  - DWELL_HI and DWELL_LO do not exist and `cfg_dwell` is ignored.
  - FALL follows RISE directly.
  - RISE follows FALL directly.

## Structure
- **Package `tri_ctrl_pkg`:** state enum (`ST_IDLE`, `ST_RISE`, `ST_FALL`, `ST_DWELL_HI`, `ST_DWELL_LO`) and the default widths `W`/`CW`.
- **Sub-module `tri_tick_div`:** 16-bit prescaler with synchronous `restart` input and a one-cycle `tick` output.
- **Top module:** holds the FSM, shadow registers and arithmetic.

## Test plan
- **Basic sweep:** lo=100, hi=110, step=4, div=0, ncyc=1 → `dac_code` sequence 100,104,108,110,106,102,100; `done` coincides with the final 100; `cyc_cnt = 1`.
- **Rate and run-until-stop:** lo=0, hi=0xFFFF, step=0x8000, div=3, ncyc=0 → codes 0,0x8000,0xFFFF,0x7FFF,0 with `wave_stb` every 4 clocks and no wrap; `stop` pulsed → `busy` low and `done` high one cycle later.
- **Rejected configurations:** lo=50, hi=50 with `start` → `cfg_err` pulse and `busy` stays 0; step=0 → same response.
- **Ignored starts and shadowing:** `start` and `stop` in the same cycle in IDLE → nothing happens; `start` mid-sweep with a changed `cfg_hi` → ignored and the old `hi` stays in use.
- **Reset mid-sweep:** `rst_n` low mid-sweep → all outputs 0 immediately; a subsequent `start` behaves as a fresh sweep.
- **Dwell (`TRI_DWELL_EN`):** dwell=2, div=0 → `hi` held for 2 clocks without a strobe before falling.

Source files
------------

// File: rtl/tri_ctrl_pkg.sv
// Shared types and default widths for the triangle-wave sweep sequencer.
// Optional feature macro: TRI_DWELL_EN (peak dwell states).
package tri_ctrl_pkg;

  localparam int TRI_W  = 16;
  localparam int TRI_CW = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE     = 3'd1,
    ST_FALL     = 3'd2,
    ST_DWELL_HI = 3'd3,
    ST_DWELL_LO = 3'd4
  } tri_state_t;

endpackage

// File: rtl/tri_tick_div.sv
// Update-rate prescaler: down-counter reloaded with div, tick on terminal count.
// tick is high when the count is zero, so it fires every div+1 clocks after a restart.
module tri_tick_div
  import tri_ctrl_pkg::*;
(
  input  logic        clk111,
  input  logic        rst_n,
  input  logic        restart,
  input  logic [15:0] div,
  output logic        tick
);

  logic [15:0] cnt_q;

  // Reload on restart or terminal count, otherwise count down.
  always_ff @(posedge clk111 or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || (cnt_q == 16'd0)) begin
      cnt_q <= div;
    end else begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign tick = (cnt_q == 16'd0);

endmodule

// File: rtl/triangle_sweep_ctrl.sv
// Triangle-wave sweep sequencer for the DAQ output path.
// Optional feature macro: TRI_DWELL_EN adds DWELL_HI/DWELL_LO peak hold states.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | waiting for start; config checked and latched on start
// ST_RISE     | code steps up by step each tick, clamped at hi
// ST_FALL     | code steps down by step each tick, clamped at lo
// ST_DWELL_HI | (TRI_DWELL_EN) hold hi for dwell ticks, then fall step
// ST_DWELL_LO | (TRI_DWELL_EN) hold lo for dwell ticks, then rise step
module triangle_sweep_ctrl
  import tri_ctrl_pkg::*;
#(
  parameter int W  = TRI_W,
  parameter int CW = TRI_CW
) (
  input  logic          clk111,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stop,
  input  logic [W-1:0]  cfg_lo,
  input  logic [W-1:0]  cfg_hi,
  input  logic [W-1:0]  cfg_step,
  input  logic [15:0]   cfg_div,
  input  logic [CW-1:0] cfg_ncyc,
  input  logic [15:0]   cfg_dwell,
  output logic [W-1:0]  dac_code,
  output logic          wave_stb,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [CW-1:0] cyc_cnt
);

`ifdef TRI_DWELL_EN
  localparam tri_state_t HI_NEXT = ST_DWELL_HI;
  localparam tri_state_t LO_NEXT = ST_DWELL_LO;
`else
  localparam tri_state_t HI_NEXT = ST_FALL;
  localparam tri_state_t LO_NEXT = ST_RISE;
`endif

  tri_state_t    state_q, state_nx;

  logic [W-1:0]  lo_q, hi_q, step_q;
  logic [15:0]   div_q;
  logic [CW-1:0] ncyc_q;

  logic [W-1:0]  code_q, code_nx;
  logic          stb_q, stb_nx;
  logic          done_q, done_nx;
  logic          err_q, err_nx;
  logic          busy_q, busy_nx;
  logic [CW-1:0] cyc_q, cyc_nx, cyc_inc;

  logic          load_cfg;
  logic          tick;
  logic [15:0]   div_sel;
  logic          stop_go, rise_go, fall_go;

  logic [W:0]        sum;
  logic signed [W:0] diff;
  logic              rise_hit, fall_hit, fin;

`ifdef TRI_DWELL_EN
  logic [15:0] dwell_q;
  logic [15:0] dw_q, dw_nx;
`else
  logic unused_dwell;
  assign unused_dwell = ^cfg_dwell;
`endif

  // On the accepting cycle the shadow divider is not loaded yet, so use the live value.
  assign div_sel = load_cfg ? cfg_div : div_q;

  tri_tick_div u_tick (
    .clk111  (clk111),
    .rst_n   (rst_n),
    .restart (load_cfg),
    .div     (div_sel),
    .tick    (tick)
  );

  // Step arithmetic is one bit wider than the code so it can never wrap.
  assign sum      = {1'b0, code_q} + {1'b0, step_q};
  assign rise_hit = (sum >= {1'b0, hi_q});
  assign diff     = $signed({1'b0, code_q}) - $signed({1'b0, step_q});
  assign fall_hit = (diff <= $signed({1'b0, lo_q}));
  assign cyc_inc  = (&cyc_q) ? cyc_q : cyc_q + CW'(1);
  assign fin      = (ncyc_q != '0) && (cyc_inc == ncyc_q);

  // State register.
  always_ff @(posedge clk111 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx = state_q;
    code_nx  = code_q;
    stb_nx   = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    cyc_nx   = cyc_q;
    load_cfg = 1'b0;
    stop_go  = 1'b0;
    rise_go  = 1'b0;
    fall_go  = 1'b0;
`ifdef TRI_DWELL_EN
    dw_nx    = dw_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // stop in the same cycle cancels the start outright, no error either
        if (start && !stop) begin
          if ((cfg_lo >= cfg_hi) || (cfg_step == '0)) begin
            err_nx = 1'b1;
          end else begin
            load_cfg = 1'b1;
            cyc_nx   = '0;
            code_nx  = cfg_lo;
            stb_nx   = 1'b1;
            state_nx = ST_RISE;
          end
        end
      end
      ST_RISE: begin
        if (stop)      stop_go = 1'b1;
        else if (tick) rise_go = 1'b1;
      end
      ST_FALL: begin
        if (stop)      stop_go = 1'b1;
        else if (tick) fall_go = 1'b1;
      end
`ifdef TRI_DWELL_EN
      // The tick that ends the dwell also performs the next step.
      ST_DWELL_HI: begin
        if (stop) begin
          stop_go = 1'b1;
        end else if (tick) begin
          if (dw_q == 16'd0) fall_go = 1'b1;
          else               dw_nx   = dw_q - 16'd1;
        end
      end
      ST_DWELL_LO: begin
        if (stop) begin
          stop_go = 1'b1;
        end else if (tick) begin
          if (dw_q == 16'd0) rise_go = 1'b1;
          else               dw_nx   = dw_q - 16'd1;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase

    if (stop_go) begin
      state_nx = ST_IDLE;
      done_nx  = 1'b1;
    end

    if (rise_go) begin
      stb_nx = 1'b1;
      if (rise_hit) begin
        code_nx  = hi_q;
        state_nx = HI_NEXT;
`ifdef TRI_DWELL_EN
        dw_nx    = dwell_q;
`endif
      end else begin
        code_nx  = sum[W-1:0];
        state_nx = ST_RISE;
      end
    end

    if (fall_go) begin
      stb_nx = 1'b1;
      if (fall_hit) begin
        code_nx = lo_q;
        cyc_nx  = cyc_inc;
        if (fin) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = LO_NEXT;
`ifdef TRI_DWELL_EN
          dw_nx    = dwell_q;
`endif
        end
      end else begin
        code_nx  = diff[W-1:0];
        state_nx = ST_FALL;
      end
    end
  end

  assign busy_nx = (state_nx != ST_IDLE);

  // Shadow copy of the configuration, taken only when a start is accepted.
  always_ff @(posedge clk111 or negedge rst_n) begin
    if (!rst_n) begin
      lo_q   <= '0;
      hi_q   <= '0;
      step_q <= '0;
      div_q  <= '0;
      ncyc_q <= '0;
    end else if (load_cfg) begin
      lo_q   <= cfg_lo;
      hi_q   <= cfg_hi;
      step_q <= cfg_step;
      div_q  <= cfg_div;
      ncyc_q <= cfg_ncyc;
    end
  end

`ifdef TRI_DWELL_EN
  // Dwell length shadow and the remaining-dwell down-counter.
  always_ff @(posedge clk111 or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      dw_q    <= '0;
    end else begin
      if (load_cfg) dwell_q <= cfg_dwell;
      dw_q <= dw_nx;
    end
  end
`endif

  // Registered outputs.
  always_ff @(posedge clk111 or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
      cyc_q  <= '0;
    end else begin
      code_q <= code_nx;
      stb_q  <= stb_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      busy_q <= busy_nx;
      cyc_q  <= cyc_nx;
    end
  end

  assign dac_code = code_q;
  assign wave_stb = stb_q;
  assign done     = done_q;
  assign cfg_err  = err_q;
  assign busy     = busy_q;
  assign cyc_cnt  = cyc_q;

endmodule

// File: tb/tb_triangle_sweep_ctrl.sv
// Bench for triangle_sweep_ctrl: directed and randomized sweeps against a
// code-list reference model. Follows TRI_DWELL_EN if the build defines it.
module tb_triangle_sweep_ctrl;

`ifdef TRI_DWELL_EN
  localparam bit DWELL_EN = 1'b1;
`else
  localparam bit DWELL_EN = 1'b0;
`endif

  logic        clk111 = 1'b0;
  logic        rst_n  = 1'b0;
  logic        start  = 1'b0;
  logic        stop   = 1'b0;
  logic [15:0] cfg_lo = '0, cfg_hi = '0, cfg_step = '0;
  logic [15:0] cfg_div = '0, cfg_ncyc = '0, cfg_dwell = '0;
  logic [15:0] dac_code;
  logic        wave_stb, busy, done, cfg_err;
  logic [15:0] cyc_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk111 = ~clk111;

  triangle_sweep_ctrl dut (
    .clk111    (clk111),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .cfg_lo    (cfg_lo),
    .cfg_hi    (cfg_hi),
    .cfg_step  (cfg_step),
    .cfg_div   (cfg_div),
    .cfg_ncyc  (cfg_ncyc),
    .cfg_dwell (cfg_dwell),
    .dac_code  (dac_code),
    .wave_stb  (wave_stb),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .cyc_cnt   (cyc_cnt)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_clk();
    @(posedge clk111);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: list of written codes built from clamp arithmetic on plain ints,
  // with the clock gap before each write (longer after a turnaround when dwelling).
  task automatic run_sweep(input int lo, input int hi, input int step, input int div,
                           input int ncyc, input int dwell, input int maxw, input bit disturb);
    int codes[$];
    int gaps[$];
    int cycs[$];
    int c, cyc, g;
    bit up, turned, bad, last;

    c = lo; cyc = 0; up = 1'b1; turned = 1'b0;
    codes.push_back(lo); gaps.push_back(0); cycs.push_back(0);
    while (codes.size() < maxw) begin
      g = (DWELL_EN && turned) ? (dwell + 1) * (div + 1) : div + 1;
      turned = 1'b0;
      if (up) begin
        c = (c + step >= hi) ? hi : c + step;
        if (c == hi) begin up = 1'b0; turned = 1'b1; end
      end else begin
        c = (c - step <= lo) ? lo : c - step;
        if (c == lo) begin up = 1'b1; turned = 1'b1; cyc++; end
      end
      codes.push_back(c); gaps.push_back(g); cycs.push_back(cyc);
      if (ncyc != 0 && cyc == ncyc) break;
    end

    cfg_lo = lo[15:0]; cfg_hi = hi[15:0]; cfg_step = step[15:0];
    cfg_div = div[15:0]; cfg_ncyc = ncyc[15:0]; cfg_dwell = dwell[15:0];
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check("start_code", dac_code, lo);
    check("start_stb", wave_stb, 1);
    check("start_busy", busy, 1);
    check("start_cyc", cyc_cnt, 0);

    for (int k = 1; k < codes.size(); k++) begin
      bad = 1'b0;
      for (int i = 1; i <= gaps[k]; i++) begin
        if (disturb && k == 1 && i == 1) begin
          start = 1'b1;
          cfg_hi = lo[15:0] + 16'd1;
          cfg_step = 16'd1;
        end
        tick_clk();
        start = 1'b0;
        if (i < gaps[k] && wave_stb !== 1'b0) bad = 1'b1;
      end
      last = (k == codes.size() - 1) && (ncyc != 0);
      check("stb_gap", bad, 0);
      check("stb", wave_stb, 1);
      check("code", dac_code, codes[k]);
      check("cyc_cnt", cyc_cnt, cycs[k]);
      check("done", done, last);
      check("busy", busy, !last);
    end

    if (ncyc != 0) begin
      tick_clk();
      check("end_busy", busy, 0);
      check("end_done", done, 0);
      check("end_stb", wave_stb, 0);
      check("end_cyc", cyc_cnt, ncyc);
      check("end_code", dac_code, lo);
    end else begin
      stop = 1'b1;
      tick_clk();
      stop = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_done", done, 1);
      check("stop_stb", wave_stb, 0);
      check("stop_code", dac_code, codes[codes.size() - 1]);
      tick_clk();
      check("stop_done_clr", done, 0);
    end
  endtask

  initial begin
    int lo, span, step, div, ncyc, dwell;

    // reset state
    rst_n = 1'b0;
    tick_clk();
    tick_clk();
    check("rst_code", dac_code, 0);
    check("rst_stb", wave_stb, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_cyc", cyc_cnt, 0);
    rst_n = 1'b1;
    tick_clk();

    // basic sweep 100,104,108,110,106,102,100
    run_sweep(100, 110, 4, 0, 1, 2, 100000, 1'b0);

    // full-range run-until-stop, no wrap
    run_sweep(0, 65535, 32768, 3, 0, 1, 5, 1'b0);

    // rejected configurations
    cfg_lo = 16'd50; cfg_hi = 16'd50; cfg_step = 16'd3; cfg_div = 16'd0; cfg_ncyc = 16'd1;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check("rej_eq_err", cfg_err, 1);
    check("rej_eq_busy", busy, 0);
    check("rej_eq_stb", wave_stb, 0);
    tick_clk();
    check("rej_eq_err_clr", cfg_err, 0);
    cfg_lo = 16'd10; cfg_hi = 16'd50; cfg_step = 16'd0;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check("rej_step_err", cfg_err, 1);
    check("rej_step_busy", busy, 0);
    tick_clk();
    cfg_lo = 16'd60; cfg_hi = 16'd50; cfg_step = 16'd2;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    check("rej_inv_err", cfg_err, 1);
    check("rej_inv_busy", busy, 0);
    tick_clk();

    // start and stop together in idle
    cfg_lo = 16'd10; cfg_hi = 16'd50; cfg_step = 16'd5;
    start = 1'b1; stop = 1'b1;
    tick_clk();
    start = 1'b0; stop = 1'b0;
    check("ss_busy", busy, 0);
    check("ss_err", cfg_err, 0);
    check("ss_stb", wave_stb, 0);
    check("ss_done", done, 0);
    tick_clk();

    // start mid-sweep with a changed hi is ignored
    run_sweep(0, 40, 10, 1, 1, 0, 100000, 1'b1);

    // async reset mid-sweep
    cfg_lo = 16'd1000; cfg_hi = 16'd2000; cfg_step = 16'd100;
    cfg_div = 16'd2; cfg_ncyc = 16'd0; cfg_dwell = 16'd0;
    start = 1'b1;
    tick_clk();
    start = 1'b0;
    repeat (7) tick_clk();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_code", dac_code, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_stb", wave_stb, 0);
    check("mid_rst_done", done, 0);
    #2;
    rst_n = 1'b1;
    tick_clk();
    check("post_rst_done", done, 0);
    run_sweep(1000, 1300, 70, 2, 2, 1, 100000, 1'b0);

    // randomized finite sweeps
    for (int r = 0; r < 8; r++) begin
      lo    = int'($urandom_range(0, 60000));
      span  = int'($urandom_range(1, 400));
      step  = int'($urandom_range(span / 16 + 1, span + 50));
      div   = int'($urandom_range(0, 3));
      ncyc  = int'($urandom_range(1, 3));
      dwell = int'($urandom_range(0, 3));
      run_sweep(lo, lo + span, step, div, ncyc, dwell, 100000, 1'b0);
      repeat (int'($urandom_range(0, 3))) tick_clk();
    end

    // randomized run-until-stop
    for (int r = 0; r < 2; r++) begin
      lo    = int'($urandom_range(0, 1000));
      span  = int'($urandom_range(64000, 64535));
      step  = int'($urandom_range(3000, 40000));
      div   = int'($urandom_range(0, 2));
      dwell = int'($urandom_range(0, 2));
      run_sweep(lo, lo + span, step, div, 0, dwell, int'($urandom_range(3, 30)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
